// File: rtl/fp32_mul_seq.sv
// ---------------------------------------------------------------------------
// fp32_mul_seq -- iterative IEEE-754 binary32 multiplier (round-to-nearest-even)
//
// The 24x24 significand product is built by shift-add, BITS_PER_CYCLE
// multiplier bits per MUL cycle. The result is then normalised, rounded and
// range-checked in a single RND cycle. Special operands (NaN, Inf, zero)
// bypass the datapath and are resolved directly on accept.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   in_valid/in_ready operand handshake (a, b accepted when both high)
//   a, b             binary32 multiplicand / multiplier
//   out_valid/out_ready result handshake (y and flags held until taken)
//   y                binary32 product
//   exc_invalid, exc_overflow, exc_underflow, exc_inexact
//                    exception flags, meaningful only while out_valid=1
//
// Handshake semantics: a transfer happens on a rising clk edge where valid
// and ready are both high. in_ready is high only in IDLE; out_valid is high
// only in DONE, where y and the flags stay constant until the transfer.
// ---------------------------------------------------------------------------
module fp32_mul_seq #(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] y,
    output logic        exc_invalid,
    output logic        exc_overflow,
    output logic        exc_underflow,
    output logic        exc_inexact
);
    localparam int         N    = 24 / BITS_PER_CYCLE;
    localparam logic [4:0] LAST = 5'(N - 1);

    typedef enum logic [1:0] {IDLE, MUL, RND, DONE} state_t;
    state_t state;

    logic               sign_q;
    logic [23:0]        mb_q;    // multiplier, consumed from the LSB end
    logic [47:0]        mc_q;    // multiplicand, shifted up to the current weight
    logic [47:0]        acc_q;   // partial-product accumulator
    logic signed [9:0]  e_q;     // biased product exponent before normalisation
    logic [4:0]         cnt_q;

    // Leading zeros of a 24-bit significand (24 when all zero).
    function automatic logic [4:0] lzc24(input logic [23:0] v);
        logic [4:0] lz;
        lz = 5'd24;
        for (int i = 0; i < 24; i++) begin
            if (v[i]) lz = 5'(23 - i);
        end
        return lz;
    endfunction

    // ---------------- operand decode (used on accept) ----------------
    logic [7:0]  ea, eb;
    logic [22:0] fa, fb;
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, sign_in;
    assign ea      = a[30:23];
    assign eb      = b[30:23];
    assign fa      = a[22:0];
    assign fb      = b[22:0];
    assign a_nan   = (ea == 8'hff) && (fa != 23'd0);
    assign b_nan   = (eb == 8'hff) && (fb != 23'd0);
    assign a_inf   = (ea == 8'hff) && (fa == 23'd0);
    assign b_inf   = (eb == 8'hff) && (fb == 23'd0);
    assign a_zero  = (ea == 8'h00) && (fa == 23'd0);
    assign b_zero  = (eb == 8'h00) && (fb == 23'd0);
    assign sign_in = a[31] ^ b[31];

    // Subnormals are normalised up front so the datapath always sees a
    // significand with bit 23 set; the exponent absorbs the shift.
    logic [23:0]       sig_a, sig_b, norm_a, norm_b;
    logic [4:0]        lz_a, lz_b;
    logic signed [9:0] eff_a, eff_b, e_sum;
    assign sig_a  = {ea != 8'd0, fa};
    assign sig_b  = {eb != 8'd0, fb};
    assign lz_a   = lzc24(sig_a);
    assign lz_b   = lzc24(sig_b);
    assign norm_a = sig_a << lz_a;
    assign norm_b = sig_b << lz_b;
    assign eff_a  = (ea == 8'd0) ? (10'sd1 - $signed({5'd0, lz_a})) : $signed({2'd0, ea});
    assign eff_b  = (eb == 8'd0) ? (10'sd1 - $signed({5'd0, lz_b})) : $signed({2'd0, eb});
    assign e_sum  = eff_a + eff_b - 10'sd127;

    logic        special, spec_inv;
    logic [31:0] spec_y;
    always_comb begin
        special  = 1'b1;
        spec_inv = 1'b0;
        spec_y   = '0;
        if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
            spec_y   = 32'h7fc00000;
            spec_inv = 1'b1;
        end else if (a_inf || b_inf) begin
            spec_y = {sign_in, 8'hff, 23'd0};
        end else if (a_zero || b_zero) begin
            spec_y = {sign_in, 31'd0};
        end else begin
            special = 1'b0;
        end
    end

    // ---------------- shift-add step ----------------
    logic [47:0] partial;
    always_comb begin
        partial = '0;
        for (int k = 0; k < BITS_PER_CYCLE; k++) begin
            if (mb_q[k]) partial = partial + (mc_q << k);
        end
    end

    // ---------------- normalise / round / range ----------------
    logic signed [9:0] e_n, e_r;
    logic [22:0]       m, m_f;
    logic              g, r, st, rup;
    logic [23:0]       m_sum;
    logic [9:0]        s_amt;
    logic [26:0]       v, vs, lost_mask;
    logic [23:0]       tm, t_res;
    logic              tg, tr, ts;
    logic [31:0]       rnd_y;
    logic              rnd_ovf, rnd_unf, rnd_inx;

    always_comb begin
        // Product of two normalised significands lies in [2^46, 2^48).
        if (acc_q[47]) begin
            e_n = e_q + 10'sd1;
            m   = acc_q[46:24];
            g   = acc_q[23];
            r   = acc_q[22];
            st  = |acc_q[21:0];
        end else begin
            e_n = e_q;
            m   = acc_q[45:23];
            g   = acc_q[22];
            r   = acc_q[21];
            st  = |acc_q[20:0];
        end
        rup   = g & (r | st | m[0]);
        m_sum = {1'b0, m} + {23'd0, rup};
        e_r   = m_sum[23] ? (e_n + 10'sd1) : e_n;
        m_f   = m_sum[23] ? 23'd0 : m_sum[22:0];

        // Tiny path: denormalise by 1-e (capped at 26, beyond which every
        // bit lands in sticky anyway), then round again at the new LSB.
        s_amt     = (e_n < -10'sd25) ? 10'd26 : $unsigned(10'sd1 - e_n);
        v         = {1'b1, m, g, r, st};
        vs        = v >> s_amt;
        lost_mask = ~({27{1'b1}} << s_amt);
        tm        = vs[26:3];
        tg        = vs[2];
        tr        = vs[1];
        ts        = vs[0] | (|(v & lost_mask));
        // A carry into bit 23 lands in the exponent LSB, giving exponent 1.
        t_res     = tm + {23'd0, tg & (tr | ts | tm[0])};

        rnd_y   = '0;
        rnd_ovf = 1'b0;
        rnd_unf = 1'b0;
        rnd_inx = 1'b0;
        if (e_n <= 10'sd0) begin
            rnd_y   = {sign_q, 7'd0, t_res};
            rnd_inx = tg | tr | ts;
            rnd_unf = tg | tr | ts;
        end else if (e_r >= 10'sd255) begin
            rnd_y   = {sign_q, 8'hff, 23'd0};
            rnd_ovf = 1'b1;
            rnd_inx = 1'b1;
        end else begin
            rnd_y   = {sign_q, e_r[7:0], m_f};
            rnd_inx = g | r | st;
        end
    end

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            in_ready      <= 1'b1;
            out_valid     <= 1'b0;
            y             <= '0;
            exc_invalid   <= 1'b0;
            exc_overflow  <= 1'b0;
            exc_underflow <= 1'b0;
            exc_inexact   <= 1'b0;
            sign_q        <= 1'b0;
            mb_q          <= '0;
            mc_q          <= '0;
            acc_q         <= '0;
            e_q           <= '0;
            cnt_q         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign_q   <= sign_in;
                        in_ready <= 1'b0;
                        if (special) begin
                            y           <= spec_y;
                            exc_invalid <= spec_inv;
                            out_valid   <= 1'b1;
                            state       <= DONE;
                        end else begin
                            mb_q  <= norm_b;
                            mc_q  <= {24'd0, norm_a};
                            acc_q <= '0;
                            e_q   <= e_sum;
                            cnt_q <= '0;
                            state <= MUL;
                        end
                    end
                end
                MUL: begin
                    acc_q <= acc_q + partial;
                    mc_q  <= mc_q << BITS_PER_CYCLE;
                    mb_q  <= mb_q >> BITS_PER_CYCLE;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == LAST) state <= RND;
                end
                RND: begin
                    y             <= rnd_y;
                    exc_overflow  <= rnd_ovf;
                    exc_underflow <= rnd_unf;
                    exc_inexact   <= rnd_inx;
                    out_valid     <= 1'b1;
                    state         <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid     <= 1'b0;
                        exc_invalid   <= 1'b0;
                        exc_overflow  <= 1'b0;
                        exc_underflow <= 1'b0;
                        exc_inexact   <= 1'b0;
                        in_ready      <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp32_mul_seq.sv
// ---------------------------------------------------------------------------
// tb_fp32_mul_seq -- bench for fp32_mul_seq (BITS_PER_CYCLE = 1)
//
// Directed cases carry hand-derived expectations; random cases are checked
// against an exact-integer rounding model. The driver pushes expectations
// into a queue on accept, the monitor pops them when out_valid rises.
// ---------------------------------------------------------------------------
module tb_fp32_mul_seq;
    localparam int BPC      = 1;
    localparam int N        = 24 / BPC;
    localparam int LAT_NORM = N + 2;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        in_valid  = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0, b = '0, y;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        exc_invalid, exc_overflow, exc_underflow, exc_inexact;
    logic [3:0]  flags;
    assign flags = {exc_invalid, exc_overflow, exc_underflow, exc_inexact};

    fp32_mul_seq #(.BITS_PER_CYCLE(BPC)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .y(y),
        .exc_invalid(exc_invalid), .exc_overflow(exc_overflow),
        .exc_underflow(exc_underflow), .exc_inexact(exc_inexact)
    );

    // ---------------- scoreboard state ----------------
    logic [35:0] exp_q[$];
    int          lat_q[$];
    int          acc_edge_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;

    logic rand_ready  = 1'b0;
    logic fixed_ready = 1'b1;
    always @(posedge clk) begin
        #1;
        out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : fixed_ready;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic fail(input string name);
        n_checks++;
        $display("FAIL %s", name);
    endtask

    // ---------------- reference model ----------------
    // Returns {special, y, invalid, overflow, underflow, inexact}.
    function automatic logic [36:0] ref_mul(input logic [31:0] xa, input logic [31:0] xb);
        int      ea, eb, lsbe, msb, e_unb, q, sh;
        longint  ma, mb, p, kept, rem, half;
        logic    s, tiny, inx, na, nb, ia, ib, za, zb;
        s  = xa[31] ^ xb[31];
        na = (xa[30:23] == 8'hff) && (xa[22:0] != 23'd0);
        nb = (xb[30:23] == 8'hff) && (xb[22:0] != 23'd0);
        ia = (xa[30:23] == 8'hff) && (xa[22:0] == 23'd0);
        ib = (xb[30:23] == 8'hff) && (xb[22:0] == 23'd0);
        za = (xa[30:0] == 31'd0);
        zb = (xb[30:0] == 31'd0);
        if (na || nb || (ia && zb) || (za && ib)) return {1'b1, 32'h7fc00000, 4'b1000};
        if (ia || ib) return {1'b1, s, 8'hff, 23'd0, 4'b0000};
        if (za || zb) return {1'b1, s, 31'd0, 4'b0000};
        // value = significand * 2^(exponent - 150)
        ea = int'(xa[30:23]);
        eb = int'(xb[30:23]);
        ma = longint'(xa[22:0]);
        mb = longint'(xb[22:0]);
        if (ea == 0) ea = 1; else ma = ma + (longint'(1) << 23);
        if (eb == 0) eb = 1; else mb = mb + (longint'(1) << 23);
        p    = ma * mb;
        lsbe = ea + eb - 300;
        msb  = 0;
        for (int i = 0; i < 48; i++) if (p[i]) msb = i;
        e_unb = msb + lsbe;
        tiny  = (e_unb < -126);
        q     = tiny ? -149 : (e_unb - 23);
        sh    = q - lsbe;
        rem   = 0;
        if (sh <= 0) begin
            kept = p << (-sh);
        end else if (sh > 62) begin
            kept = 0;
            rem  = p;
        end else begin
            kept = p >> sh;
            rem  = p - (kept << sh);
            half = longint'(1) << (sh - 1);
            if (rem > half || (rem == half && kept[0])) kept = kept + 1;
        end
        inx = (rem != 0);
        if (!tiny && kept == (longint'(1) << 24)) begin
            kept  = longint'(1) << 23;
            e_unb = e_unb + 1;
        end
        if (tiny) return {1'b0, s, kept[30:0], 1'b0, 1'b0, inx, inx};
        if (e_unb > 127) return {1'b0, s, 8'hff, 23'd0, 4'b0101};
        return {1'b0, s, 8'(e_unb + 127), kept[22:0], 3'b000, inx};
    endfunction

    function automatic logic [31:0] rand_fp();
        logic        s;
        logic [22:0] f;
        s = 1'($urandom_range(0, 1));
        f = 23'($urandom);
        case ($urandom_range(0, 11))
            0:       return {s, 31'd0};
            1:       return {s, 8'hff, 23'd0};
            2:       return {s, 8'hff, f | 23'd1};
            3:       return {s, 8'd0, f};
            4:       return {s, 8'($urandom_range(200, 254)), f};
            5:       return {s, 8'($urandom_range(1, 40)), f};
            6:       return $urandom;
            default: return {s, 8'($urandom_range(100, 154)), f};
        endcase
    endfunction

    // ---------------- driver ----------------
    task automatic send(input logic [31:0] xa, input logic [31:0] xb,
                        input logic [35:0] e, input int l);
        int w;
        w = 0;
        @(posedge clk); #1;
        in_valid = 1'b1;
        a = xa;
        b = xb;
        @(negedge clk);
        while (!in_ready && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            fail("accept_timeout");
            in_valid = 1'b0;
            return;
        end
        exp_q.push_back(e);
        lat_q.push_back(l);
        acc_edge_q.push_back(cyc + 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((exp_q.size() != 0 || out_valid) && w < 500) begin
            @(negedge clk);
            w++;
        end
        if (w >= 500) fail("drain_timeout");
    endtask

    // ---------------- monitor ----------------
    logic        prev_valid = 1'b0;
    logic [35:0] hold_val   = '0;
    always @(negedge clk) begin
        logic [35:0] e;
        int          l, ae;
        if (out_valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
                fail("unexpected_result");
            end else begin
                e  = exp_q.pop_front();
                l  = lat_q.pop_front();
                ae = acc_edge_q.pop_front();
                check("result", {y, flags}, e);
                check("latency", 64'(cyc - ae + 1), 64'(l));
            end
            hold_val = {y, flags};
        end else if (out_valid) begin
            check("hold_stable", {y, flags}, hold_val);
        end
        if (out_valid) check("in_ready_low_in_done", in_ready, 0);
        else           check("flags_zero_when_idle", flags, 0);
        prev_valid = out_valid;
    end

    // ---------------- main sequence ----------------
    initial begin
        int w;
        logic [31:0] ra, rb;
        logic [36:0] r;

        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_y", y, 0);
        check("reset_flags", flags, 0);
        rst_n = 1'b1;

        // Directed cases: {y, invalid, overflow, underflow, inexact}
        send(32'h3fc00000, 32'h40000000, {32'h40400000, 4'b0000}, LAT_NORM);
        send(32'h3f800001, 32'h3f800001, {32'h3f800002, 4'b0001}, LAT_NORM);
        send(32'h7f7fffff, 32'h40000000, {32'h7f800000, 4'b0101}, LAT_NORM);
        send(32'hff800000, 32'h00000000, {32'h7fc00000, 4'b1000}, 1);
        send(32'h00000001, 32'h3f000000, {32'h00000000, 4'b0011}, LAT_NORM);
        send(32'h00400000, 32'h40000000, {32'h00800000, 4'b0000}, LAT_NORM);
        send(32'hc0000000, 32'hff800000, {32'h7f800000, 4'b0000}, 1);
        send(32'h80000000, 32'h40a00000, {32'h80000000, 4'b0000}, 1);
        send(32'h7fc00001, 32'h3f800000, {32'h7fc00000, 4'b1000}, 1);
        drain();

        // Backpressure: result must hold and extra operands must be ignored.
        fixed_ready = 1'b0;
        send(32'h3fc00000, 32'h40000000, {32'h40400000, 4'b0000}, LAT_NORM);
        w = 0;
        while (!out_valid && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!out_valid) fail("bp_out_valid_timeout");
        @(posedge clk); #1;
        in_valid = 1'b1;
        a = 32'h3f800000;
        b = 32'h3f800000;
        repeat (5) @(negedge clk);
        check("bp_y_held", y, 32'h40400000);
        check("bp_in_ready", in_ready, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        fixed_ready = 1'b1;
        w = 0;
        while (out_valid && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("bp_released", out_valid, 0);
        check("bp_idle_in_ready", in_ready, 1);
        repeat (4) @(negedge clk);
        check("bp_no_extra_result", out_valid, 0);
        check("bp_queue_empty", 64'(exp_q.size()), 0);

        // Reset during MUL discards the operation.
        @(posedge clk); #1;
        in_valid = 1'b1;
        a = 32'h3fc00000;
        b = 32'h40000000;
        @(negedge clk);
        check("rst_pre_accept_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #3;
        check("rst_busy_before", in_ready, 0);
        rst_n = 1'b0;
        #1;
        check("rst_async_out_valid", out_valid, 0);
        check("rst_async_y", y, 0);
        check("rst_async_in_ready", in_ready, 1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(32'h3f800000, 32'h3f800000, {32'h3f800000, 4'b0000}, LAT_NORM);
        drain();

        // Randomised traffic with random output backpressure.
        rand_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            ra = rand_fp();
            rb = rand_fp();
            r  = ref_mul(ra, rb);
            send(ra, rb, r[35:0], r[36] ? 1 : LAT_NORM);
        end
        drain();
        rand_ready = 1'b0;

        check("scoreboard_empty", 64'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
